// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, window column type and the Sobel 1-2-1 difference kernel
package sobel_pkg;
    localparam int PIX_W  = 8;
    localparam int GRAD_W = 11;
    localparam int SQ_W   = 20;
    localparam int SUM_W  = 21;
    localparam int RAD_W  = 16;

    typedef logic signed [GRAD_W-1:0] grad_t;
    // [0]=row-2 (top), [1]=row-1, [2]=current row (bottom)
    typedef logic [2:0][PIX_W-1:0] col_t;

    // (b0+2b1+b2)-(a0+2a1+a2); wraps in GRAD_W bits, which is exact for 8-bit inputs
    function automatic grad_t kern(
        input logic [PIX_W-1:0] a0, a1, a2,
        input logic [PIX_W-1:0] b0, b1, b2
    );
        logic [GRAD_W-1:0] n, p;
        n = GRAD_W'(a0) + (GRAD_W'(a1) << 1) + GRAD_W'(a2);
        p = GRAD_W'(b0) + (GRAD_W'(b1) << 1) + GRAD_W'(b2);
        return grad_t'(p - n);
    endfunction
endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: one-line pixel delay, read-before-write at the same column address
//   clk    : clock
//   i_en   : write enable (pixel accepted)
//   i_addr : current column
//   i_din  : pixel to store for the next line
//   o_dout : pixel stored at this column one line ago
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_din,
    output logic [PIX_W-1:0] o_dout
);
    logic [PIX_W-1:0] r_mem [DEPTH];

    assign o_dout = r_mem[i_addr];

    always_ff @(posedge clk)
        if (i_en) r_mem[i_addr] <= i_din;
endmodule

// File: rtl/sobel_grad_sq.sv
// sobel_grad_sq: streaming 3x3 Sobel, emits saturated (Gx^2+Gy^2)>>RAD_SHIFT per interior pixel
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : pixel handshake; in_pixel data, in_sof forces position (0,0)
//   out_valid/out_ready : radicand handshake; out_rad value, out_last ends the frame
//   out_sat             : only with SOBEL_SAT_FLAG_EN, flags a clipped radicand
module sobel_grad_sq
    import sobel_pkg::*;
#(
    parameter int IMG_W     = 64,
    parameter int IMG_H     = 64,
    parameter int RAD_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RAD_W-1:0] out_rad,
`ifdef SOBEL_SAT_FLAG_EN
    output logic             out_sat,
`endif
    output logic             out_last
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic             r_up;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic             w_en, w_acc, w_col_end, w_row_end;
    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    logic [PIX_W-1:0] w_lb1, w_lb2;

    col_t             r_c0, r_c1, r_c2;
    logic             r_v1, r_l1;
    grad_t            w_gx, w_gy;
    logic [GRAD_W-2:0] w_ax, w_ay;
    logic [SQ_W-1:0]  r_sqx, r_sqy;
    logic             r_v2, r_l2;
    logic [SUM_W-1:0] w_sum, w_shr;
    logic             w_sat;
    logic [RAD_W-1:0] r_rad;
    logic             r_v3, r_l3;
`ifdef SOBEL_SAT_FLAG_EN
    logic             r_sat;
    assign out_sat = r_sat;
`endif

    // whole pipeline advances together; stalls only when the output is held
    assign w_en      = !r_v3 | out_ready;
    assign in_ready  = w_en & r_up;
    assign w_acc     = in_valid & in_ready;
    assign w_col     = in_sof ? '0 : r_col;
    assign w_row     = in_sof ? '0 : r_row;
    assign w_col_end = w_col == CW'(IMG_W - 1);
    assign w_row_end = w_row == RW'(IMG_H - 1);

    sobel_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .clk(clk), .i_en(w_acc), .i_addr(w_col), .i_din(in_pixel), .o_dout(w_lb1)
    );
    sobel_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb2 (
        .clk(clk), .i_en(w_acc), .i_addr(w_col), .i_din(w_lb1), .o_dout(w_lb2)
    );

    assign w_gx  = kern(r_c0[0], r_c0[1], r_c0[2], r_c2[0], r_c2[1], r_c2[2]);
    assign w_gy  = kern(r_c0[0], r_c1[0], r_c2[0], r_c0[2], r_c1[2], r_c2[2]);
    // |G| <= 1020 fits in GRAD_W-1 bits
    assign w_ax  = w_gx[GRAD_W-1] ? (GRAD_W-1)'(-w_gx) : w_gx[GRAD_W-2:0];
    assign w_ay  = w_gy[GRAD_W-1] ? (GRAD_W-1)'(-w_gy) : w_gy[GRAD_W-2:0];
    assign w_sum = SUM_W'(r_sqx) + SUM_W'(r_sqy);
    assign w_shr = w_sum >> RAD_SHIFT;
    assign w_sat = |w_shr[SUM_W-1:RAD_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up  <= 1'b0;
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_up <= 1'b1;
            if (w_acc) begin
                r_col <= w_col_end ? '0 : w_col + 1'b1;
                r_row <= w_col_end ? (w_row_end ? '0 : w_row + 1'b1) : w_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c0  <= '0;
            r_c1  <= '0;
            r_c2  <= '0;
            r_v1  <= 1'b0;
            r_l1  <= 1'b0;
            r_sqx <= '0;
            r_sqy <= '0;
            r_v2  <= 1'b0;
            r_l2  <= 1'b0;
            r_rad <= '0;
            r_v3  <= 1'b0;
            r_l3  <= 1'b0;
`ifdef SOBEL_SAT_FLAG_EN
            r_sat <= 1'b0;
`endif
        end else if (w_en) begin
            if (w_acc) begin
                r_c0 <= r_c1;
                r_c1 <= r_c2;
                r_c2 <= {in_pixel, w_lb1, w_lb2};
            end
            r_v1  <= w_acc & (w_row >= RW'(2)) & (w_col >= CW'(2));
            r_l1  <= w_acc & w_row_end & w_col_end;
            r_sqx <= SQ_W'(w_ax) * SQ_W'(w_ax);
            r_sqy <= SQ_W'(w_ay) * SQ_W'(w_ay);
            r_v2  <= r_v1;
            r_l2  <= r_l1;
            r_rad <= w_sat ? '1 : w_shr[RAD_W-1:0];
            r_v3  <= r_v2;
            r_l3  <= r_l2;
`ifdef SOBEL_SAT_FLAG_EN
            r_sat <= w_sat;
`endif
        end
    end

    assign out_valid = r_v3;
    assign out_rad   = r_rad;
    assign out_last  = r_l3;
endmodule

// File: doc/sobel_grad_sq.md
Name: sobel_grad_sq

Overview:
Streaming Sobel front end that feeds the approximate square-root stage.
- Accepts a raster-order 8-bit grayscale pixel stream and builds a 3x3 window using two line buffers.
- Computes Gx and Gy, then emits the 16-bit radicand (Gx²+Gy²)>>RAD_SHIFT, saturated, over a valid/ready interface.
- Its output connects directly to the 16-bit radicand input of the square-root block.

Parameters:
IMG_W, 64, pixels per line (≥3)
IMG_H, 64, lines per frame (≥3)
RAD_SHIFT, 2, right shift applied to the 21-bit sum of squares before saturation to 16 bits (0..5)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  pixel valid
in_ready  out  1  block can accept a pixel this cycle
in_pixel  in  8  unsigned pixel
in_sof  in  1  first pixel of frame; sampled with in_valid&in_ready
out_valid  out  1  radicand valid
out_ready  in  1  downstream accepts
out_rad  out  16  saturated (Gx²+Gy²)>>RAD_SHIFT
out_last  out  1  marks the final radicand of the frame

Behaviour:
Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous, active-low.

Reset:
- out_valid=0, out_rad=0, out_last=0.
- Row/col counters=0; all pipeline valid bits=0.
- in_ready=1 one cycle after reset deasserts.
- Line-buffer contents are don't-care and are never observable; see masking below.

Handshake:
- Global advance en = !out_valid | out_ready.
- in_ready = en.
- A pixel is accepted on in_valid&in_ready. Data is held stable under stall; there are no bubbles except those due to in_valid.

Counters:
- col increments per accepted pixel. At IMG_W-1 it wraps to 0 and row increments.
- After (IMG_H-1, IMG_W-1), both wrap to 0.
- An accepted pixel with in_sof=1 is forced to (0,0) regardless of counter state. Counters continue from there and the old frame is abandoned.
- In-flight results of the abandoned frame still drain in order.

Window:
- Line buffers lb1 (row-1) and lb2 (row-2) are IMG_W×8 each and are read/written at col.
- Three column shift registers hold columns col-2..col.
- The window is valid only when row≥2 and col≥2, with the accepted pixel at the bottom-right. This gives (IMG_W-2)·(IMG_H-2) outputs per frame.
- Border pixels produce no output.

Arithmetic (p[r][c], r/c=0..2, top-left origin):
- Gx = (p02+2p12+p22) − (p00+2p10+p20), 11-bit signed.
- Gy = (p20+2p21+p22) − (p00+2p01+p02), 11-bit signed.
- Squares are 20-bit unsigned; their sum is 21-bit, max 2,080,800.
- Shift right by RAD_SHIFT, then saturate to 0xFFFF.

Pipeline and latency:
- S1 (window register, Gx/Gy) → S2 (squares) → S3 (sum, shift, saturate, output register).
- out_valid rises 3 cycles after acceptance of the bottom-right pixel when out_ready=1.
- Under backpressure all stages freeze; no data is lost or duplicated and order is preserved.
- out_last=1 with the radicand whose window ends at (IMG_H-1, IMG_W-1).

Simultaneous events:
- in_sof together with an ongoing stall: the pixel is not accepted, so there is no counter effect.
- Reset mid-frame: the pipeline is flushed; the next frame must begin with in_sof or at natural (0,0).

Optional Feature:
Macro: SOBEL_SAT_FLAG_EN.
- Defined: adds output port out_sat (1 bit), aligned with out_rad. It is 1 when the shifted sum exceeded 0xFFFF; reset value 0.
- Undefined: no port and no logic; saturation still applies silently.

Decomposition:
- Package sobel_pkg: PIX_W=8, GRAD_W=11, SQ_W=20, SUM_W=21, RAD_W=16, and a typedef for the signed gradient.
- Sub-module sobel_line_buffer: single-port-per-cycle IMG_W-deep delay line with a write/read enable tied to acceptance. Instantiated twice.

Test Plan:
1. 8×8 frame, all pixels 100, out_ready=1 → exactly 36 outputs, all out_rad=0; out_last only on the 36th.
2. 8×8 frame with pixel=col → every output Gx=8, Gy=0, out_rad=16 (64>>2).
3. 8×8 frame with left 4 columns 0 and right 4 columns 255 → windows straddling the edge give Gx=1020, out_rad=0xFFFF (out_sat=1 if enabled); others give 0.
4. Hold out_ready=0 for 10 cycles mid-frame → in_ready drops once the output register fills. Resumed output matches the no-stall reference sequence exactly, with no drop or duplicate.
5. in_sof asserted at (row 4, col 3) of a frame → counters restart. The next frame yields 36 outputs with correct values; prior in-flight results emerge first.
6. Assert rst_n=0 mid-frame → out_valid=0 immediately (async). After release plus a full new frame, outputs match scenario 1/2 exactly.
